// File: rtl/vga_wbm_arb.sv
// rtl/vga_wbm_arb.sv - two-requester Wishbone master arbiter for the VGA fetch bus
// Optional bus timeout when VGA_ARB_TIMEOUT_EN is defined.
module vga_wbm_arb #(
    parameter int RR_EN   = 0,
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        rst_nreset_i,

    input  logic        r0_cyc_i,
    input  logic        r0_stb_i,
    input  logic        r0_cab_i,
    input  logic [29:0] r0_adr_i,
    input  logic [3:0]  r0_sel_i,
    output logic        r0_ack_o,
    output logic        r0_err_o,
    output logic        r0_gnt_o,

    input  logic        r1_cyc_i,
    input  logic        r1_stb_i,
    input  logic        r1_cab_i,
    input  logic [29:0] r1_adr_i,
    input  logic [3:0]  r1_sel_i,
    output logic        r1_ack_o,
    output logic        r1_err_o,
    output logic        r1_gnt_o,

    output logic [29:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    output logic        wb_cab_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam bit RR = (RR_EN != 0);

    state_t state;
    logic   last_gnt;
    logic   req0;
    logic   req1;
    logic   timeout0;
    logic   timeout1;

`ifdef VGA_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    logic [7:0] to_cnt;
    logic       to_hit;
    logic       mask0;
    logic       mask1;

    assign to_hit   = (r0_gnt_o | r1_gnt_o) & wb_stb_o & ~wb_ack_i & ~wb_err_i
                      & (to_cnt == TO_LIMIT);
    assign timeout0 = to_hit & r0_gnt_o;
    assign timeout1 = to_hit & r1_gnt_o;

    // A timed-out owner stays masked until it has let go of cyc once.
    assign req0 = r0_cyc_i & ~mask0;
    assign req1 = r1_cyc_i & ~mask1;

    always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            to_cnt <= 8'd0;
            mask0  <= 1'b0;
            mask1  <= 1'b0;
        end else begin
            if (state == IDLE || wb_ack_i || wb_err_i || to_hit)
                to_cnt <= 8'd0;
            else if (wb_stb_o)
                to_cnt <= to_cnt + 8'd1;

            if (timeout0)
                mask0 <= 1'b1;
            else if (!r0_cyc_i)
                mask0 <= 1'b0;

            if (timeout1)
                mask1 <= 1'b1;
            else if (!r1_cyc_i)
                mask1 <= 1'b0;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT;
    assign timeout0       = 1'b0;
    assign timeout1       = 1'b0;
    assign req0           = r0_cyc_i;
    assign req1           = r1_cyc_i;
`endif

    // last_gnt = 1 means requester 1 was granted most recently.
    always_ff @(posedge wb_clk_i or negedge rst_nreset_i) begin
        if (!rst_nreset_i) begin
            state    <= IDLE;
            r0_gnt_o <= 1'b0;
            r1_gnt_o <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || !RR || last_gnt)) begin
                        state    <= GNT0;
                        r0_gnt_o <= 1'b1;
                        last_gnt <= 1'b0;
                    end else if (req1) begin
                        state    <= GNT1;
                        r1_gnt_o <= 1'b1;
                        last_gnt <= 1'b1;
                    end
                end
                GNT0: begin
                    if (!r0_cyc_i || timeout0) begin
                        state    <= IDLE;
                        r0_gnt_o <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!r1_cyc_i || timeout1) begin
                        state    <= IDLE;
                        r1_gnt_o <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    r0_gnt_o <= 1'b0;
                    r1_gnt_o <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        wb_cab_o = 1'b0;
        wb_adr_o = 30'd0;
        wb_sel_o = 4'd0;
        if (r0_gnt_o) begin
            wb_cyc_o = r0_cyc_i;
            wb_stb_o = r0_stb_i;
            wb_cab_o = r0_cab_i;
            wb_adr_o = r0_adr_i;
            wb_sel_o = r0_sel_i;
        end else if (r1_gnt_o) begin
            wb_cyc_o = r1_cyc_i;
            wb_stb_o = r1_stb_i;
            wb_cab_o = r1_cab_i;
            wb_adr_o = r1_adr_i;
            wb_sel_o = r1_sel_i;
        end
    end

    assign wb_we_o  = 1'b0;

    assign r0_ack_o = wb_ack_i & r0_gnt_o & r0_stb_i;
    assign r1_ack_o = wb_ack_i & r1_gnt_o & r1_stb_i;
    assign r0_err_o = (wb_err_i & r0_gnt_o & r0_stb_i) | timeout0;
    assign r1_err_o = (wb_err_i & r1_gnt_o & r1_stb_i) | timeout1;

endmodule

// File: tb/tb_vga_wbm_arb.sv
// tb/tb_vga_wbm_arb.sv - directed self-checking bench for vga_wbm_arb (fixed-priority and round-robin instances)
module tb_vga_wbm_arb;

    logic        clk;
    logic        rst_n;
    logic        r0_cyc, r0_stb, r0_cab;
    logic [29:0] r0_adr;
    logic [3:0]  r0_sel;
    logic        r1_cyc, r1_stb, r1_cab;
    logic [29:0] r1_adr;
    logic [3:0]  r1_sel;
    logic        wb_ack, wb_err;

    logic        a_r0_ack, a_r0_err, a_r0_gnt, a_r1_ack, a_r1_err, a_r1_gnt;
    logic [29:0] a_adr;
    logic [3:0]  a_sel;
    logic        a_we, a_stb, a_cyc, a_cab;

    logic        b_r0_ack, b_r0_err, b_r0_gnt, b_r1_ack, b_r1_err, b_r1_gnt;
    logic [29:0] b_adr;
    logic [3:0]  b_sel;
    logic        b_we, b_stb, b_cyc, b_cab;

    int n_checks = 0;
    int n_fail   = 0;

    vga_wbm_arb #(.RR_EN(0), .TIMEOUT(16)) dut_fixed (
        .wb_clk_i(clk), .rst_nreset_i(rst_n),
        .r0_cyc_i(r0_cyc), .r0_stb_i(r0_stb), .r0_cab_i(r0_cab), .r0_adr_i(r0_adr), .r0_sel_i(r0_sel),
        .r0_ack_o(a_r0_ack), .r0_err_o(a_r0_err), .r0_gnt_o(a_r0_gnt),
        .r1_cyc_i(r1_cyc), .r1_stb_i(r1_stb), .r1_cab_i(r1_cab), .r1_adr_i(r1_adr), .r1_sel_i(r1_sel),
        .r1_ack_o(a_r1_ack), .r1_err_o(a_r1_err), .r1_gnt_o(a_r1_gnt),
        .wb_adr_o(a_adr), .wb_sel_o(a_sel), .wb_we_o(a_we), .wb_stb_o(a_stb),
        .wb_cyc_o(a_cyc), .wb_cab_o(a_cab), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
    );

    vga_wbm_arb #(.RR_EN(1), .TIMEOUT(16)) dut_rr (
        .wb_clk_i(clk), .rst_nreset_i(rst_n),
        .r0_cyc_i(r0_cyc), .r0_stb_i(r0_stb), .r0_cab_i(r0_cab), .r0_adr_i(r0_adr), .r0_sel_i(r0_sel),
        .r0_ack_o(b_r0_ack), .r0_err_o(b_r0_err), .r0_gnt_o(b_r0_gnt),
        .r1_cyc_i(r1_cyc), .r1_stb_i(r1_stb), .r1_cab_i(r1_cab), .r1_adr_i(r1_adr), .r1_sel_i(r1_sel),
        .r1_ack_o(b_r1_ack), .r1_err_o(b_r1_err), .r1_gnt_o(b_r1_gnt),
        .wb_adr_o(b_adr), .wb_sel_o(b_sel), .wb_we_o(b_we), .wb_stb_o(b_stb),
        .wb_cyc_o(b_cyc), .wb_cab_o(b_cab), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        r0_cyc = 0; r0_stb = 0; r0_cab = 0; r0_adr = '0; r0_sel = '0;
        r1_cyc = 0; r1_stb = 0; r1_cab = 0; r1_adr = '0; r1_sel = '0;
        wb_ack = 0; wb_err = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        step();
        step();
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        r0_cyc = 1; r0_stb = 1; r0_cab = 1; r0_adr = 30'h55; r0_sel = 4'hF;
        wb_ack = 1; wb_err = 1;
        step();
        step();
        n_checks++; if ({a_r0_gnt, a_r1_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", {a_r0_gnt, a_r1_gnt}); end
        n_checks++; if ({a_cyc, a_stb, a_cab, a_we} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl: got %b want 0000", {a_cyc, a_stb, a_cab, a_we}); end
        n_checks++; if (a_adr !== 30'h0) begin n_fail++; $display("FAIL reset_adr: got %h want 0", a_adr); end
        n_checks++; if (a_sel !== 4'h0) begin n_fail++; $display("FAIL reset_sel: got %h want 0", a_sel); end
        n_checks++; if ({a_r0_ack, a_r0_err, a_r1_ack, a_r1_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_ackerr: got %b want 0000", {a_r0_ack, a_r0_err, a_r1_ack, a_r1_err}); end
        n_checks++; if ({b_r0_gnt, b_r1_gnt, b_cyc} !== 3'b000) begin n_fail++; $display("FAIL reset_rr: got %b want 000", {b_r0_gnt, b_r1_gnt, b_cyc}); end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        r0_adr = 30'h0000100; r0_sel = 4'hF; r0_cyc = 1; r0_stb = 1;
        wb_ack = 1;
        #1;
        n_checks++; if ({a_r0_ack, a_cyc} !== 2'b00) begin n_fail++; $display("FAIL idle_ack_ignored: got %b want 00", {a_r0_ack, a_cyc}); end
        wb_ack = 0;
        step();
        n_checks++; if ({a_r0_gnt, a_r1_gnt, a_cyc, a_stb, a_we} !== 5'b10110) begin n_fail++; $display("FAIL single_grant: got %b want 10110", {a_r0_gnt, a_r1_gnt, a_cyc, a_stb, a_we}); end
        n_checks++; if (a_adr !== 30'h0000100) begin n_fail++; $display("FAIL single_adr: got %h want 0000100", a_adr); end
        n_checks++; if (a_sel !== 4'hF) begin n_fail++; $display("FAIL single_sel: got %h want f", a_sel); end
        step();
        step();
        wb_ack = 1;
        #1;
        n_checks++; if ({a_r0_ack, a_r1_ack} !== 2'b10) begin n_fail++; $display("FAIL single_ack: got %b want 10", {a_r0_ack, a_r1_ack}); end
        step();
        wb_ack = 0; r0_cyc = 0; r0_stb = 0;
        #1;
        n_checks++; if (a_cyc !== 1'b0) begin n_fail++; $display("FAIL single_cyc_drop: got %b want 0", a_cyc); end
        step();
        n_checks++; if (a_r0_gnt !== 1'b0) begin n_fail++; $display("FAIL single_release: got %b want 0", a_r0_gnt); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            r0_cyc = 1; r0_stb = 1; r1_cyc = 1; r1_stb = 1;
            step();
            n_checks++; if ({a_r0_gnt, a_r1_gnt, a_cyc} !== 3'b101) begin n_fail++; $display("FAIL fixed_grant%0d: got %b want 101", i, {a_r0_gnt, a_r1_gnt, a_cyc}); end
            r0_cyc = 0; r0_stb = 0;
            step();
            n_checks++; if ({a_r0_gnt, a_r1_gnt, a_cyc} !== 3'b000) begin n_fail++; $display("FAIL fixed_gap%0d: got %b want 000", i, {a_r0_gnt, a_r1_gnt, a_cyc}); end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_win;
        logic [1:0] want;
        exp_win = 4'b1010;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            r0_cyc = 1; r0_stb = 1; r1_cyc = 1; r1_stb = 1;
            step();
            want = exp_win[i] ? 2'b01 : 2'b10;
            n_checks++; if ({b_r0_gnt, b_r1_gnt} !== want) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", i, {b_r0_gnt, b_r1_gnt}, want); end
            if (exp_win[i]) begin r1_cyc = 0; r1_stb = 0; end
            else begin r0_cyc = 0; r0_stb = 0; end
            #1;
            n_checks++; if (b_cyc !== 1'b0) begin n_fail++; $display("FAIL rr_cyc_drop%0d: got %b want 0", i, b_cyc); end
            step();
            n_checks++; if ({b_r0_gnt, b_r1_gnt, b_cyc} !== 3'b000) begin n_fail++; $display("FAIL rr_gap%0d: got %b want 000", i, {b_r0_gnt, b_r1_gnt, b_cyc}); end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_burst();
        logic [29:0] exp_adr;
        do_reset();
        r1_cyc = 1; r1_stb = 1; r1_cab = 1; r1_adr = 30'h2000; r1_sel = 4'h3;
        step();
        for (int beat = 0; beat < 8; beat++) begin
            exp_adr = 30'h2000 + 30'(beat);
            r1_adr = exp_adr;
            wb_ack = 1;
            if (beat == 2) begin r0_cyc = 1; r0_stb = 1; r0_adr = 30'h3333; r0_sel = 4'hC; end
            #1;
            n_checks++; if ({a_r1_ack, a_r0_ack, a_r1_gnt, a_r0_gnt, a_cab} !== 5'b10101) begin n_fail++; $display("FAIL burst_beat%0d: got %b want 10101", beat, {a_r1_ack, a_r0_ack, a_r1_gnt, a_r0_gnt, a_cab}); end
            n_checks++; if (a_adr !== exp_adr) begin n_fail++; $display("FAIL burst_adr%0d: got %h want %h", beat, a_adr, exp_adr); end
            step();
        end
        wb_ack = 0; r1_cyc = 0; r1_stb = 0; r1_cab = 0;
        #1;
        n_checks++; if ({a_r0_gnt, a_cyc} !== 2'b00) begin n_fail++; $display("FAIL burst_drop: got %b want 00", {a_r0_gnt, a_cyc}); end
        step();
        n_checks++; if ({a_r0_gnt, a_r1_gnt, a_cyc} !== 3'b000) begin n_fail++; $display("FAIL burst_idle: got %b want 000", {a_r0_gnt, a_r1_gnt, a_cyc}); end
        step();
        n_checks++; if ({a_r0_gnt, b_r0_gnt, a_cyc} !== 3'b111) begin n_fail++; $display("FAIL burst_handover: got %b want 111", {a_r0_gnt, b_r0_gnt, a_cyc}); end
        n_checks++; if ({a_adr, a_sel} !== {30'h3333, 4'hC}) begin n_fail++; $display("FAIL burst_r0_adr: got %h/%h want 3333/c", a_adr, a_sel); end
        clear_inputs();
        step();
    endtask

    task automatic test_err();
        do_reset();
        r0_cyc = 1; r0_stb = 1; r0_adr = 30'h40;
        step();
        wb_err = 1;
        #1;
        n_checks++; if ({a_r0_err, a_r1_err, a_r0_ack} !== 3'b100) begin n_fail++; $display("FAIL err_pass: got %b want 100", {a_r0_err, a_r1_err, a_r0_ack}); end
        step();
        wb_err = 0;
        #1;
        n_checks++; if ({a_r0_err, a_r0_gnt} !== 2'b01) begin n_fail++; $display("FAIL err_one_cycle: got %b want 01", {a_r0_err, a_r0_gnt}); end
        step();
        step();
        n_checks++; if ({a_r0_gnt, a_cyc} !== 2'b11) begin n_fail++; $display("FAIL err_hold: got %b want 11", {a_r0_gnt, a_cyc}); end
        r0_cyc = 0; r0_stb = 0;
        step();
        n_checks++; if (a_r0_gnt !== 1'b0) begin n_fail++; $display("FAIL err_release: got %b want 0", a_r0_gnt); end
        clear_inputs();
        step();
    endtask

    task automatic test_timeout();
        logic early;
        do_reset();
        early = 0;
        r0_cyc = 1; r0_stb = 1; r0_adr = 30'h77;
        step();
`ifdef VGA_ARB_TIMEOUT_EN
        r1_cyc = 1; r1_stb = 1; r1_adr = 30'h88;
        for (int k = 0; k < 16; k++) begin
            if (a_r0_err !== 1'b0 || a_r0_gnt !== 1'b1) early = 1;
            step();
        end
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", early); end
        n_checks++; if ({a_r0_err, a_r1_err, a_cyc} !== 3'b101) begin n_fail++; $display("FAIL to_pulse: got %b want 101", {a_r0_err, a_r1_err, a_cyc}); end
        step();
        n_checks++; if ({a_cyc, a_r0_err, a_r0_gnt, a_r1_gnt} !== 4'b0000) begin n_fail++; $display("FAIL to_release: got %b want 0000", {a_cyc, a_r0_err, a_r0_gnt, a_r1_gnt}); end
        step();
        n_checks++; if ({a_r0_gnt, a_r1_gnt, b_r0_gnt, b_r1_gnt} !== 4'b0101) begin n_fail++; $display("FAIL to_next_owner: got %b want 0101", {a_r0_gnt, a_r1_gnt, b_r0_gnt, b_r1_gnt}); end
`else
        for (int k = 0; k < 300; k++) begin
            if (a_r0_err !== 1'b0 || a_r0_gnt !== 1'b1) early = 1;
            step();
        end
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL hold_no_err: got %b want 0", early); end
        n_checks++; if ({a_r0_gnt, a_cyc, a_stb} !== 3'b111) begin n_fail++; $display("FAIL hold_300: got %b want 111", {a_r0_gnt, a_cyc, a_stb}); end
`endif
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        r1_cyc = 1; r1_stb = 1; r1_cab = 1; r1_adr = 30'h1234; r1_sel = 4'hF;
        step();
        wb_ack = 1;
        step();
        step();
        n_checks++; if ({a_r1_gnt, a_cab} !== 2'b11) begin n_fail++; $display("FAIL areset_pre: got %b want 11", {a_r1_gnt, a_cab}); end
        #2;
        rst_n = 0;
        #1;
        n_checks++; if ({a_r1_gnt, a_cyc, a_stb, a_cab, a_r1_ack} !== 5'b00000) begin n_fail++; $display("FAIL areset_ctl: got %b want 00000", {a_r1_gnt, a_cyc, a_stb, a_cab, a_r1_ack}); end
        n_checks++; if ({a_adr, a_sel} !== 34'h0) begin n_fail++; $display("FAIL areset_adr: got %h/%h want 0/0", a_adr, a_sel); end
        n_checks++; if ({b_r1_gnt, b_cyc} !== 2'b00) begin n_fail++; $display("FAIL areset_rr: got %b want 00", {b_r1_gnt, b_cyc}); end
        wb_ack = 0; r1_cab = 0;
        r0_cyc = 1; r0_stb = 1;
        @(negedge clk);
        rst_n = 1;
        step();
        n_checks++; if ({a_r0_gnt, a_r1_gnt, b_r0_gnt, b_r1_gnt} !== 4'b1010) begin n_fail++; $display("FAIL areset_first: got %b want 1010", {a_r0_gnt, a_r1_gnt, b_r0_gnt, b_r1_gnt}); end
        clear_inputs();
        step();
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_fixed_priority();
        test_round_robin();
        test_burst();
        test_err();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
